// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// score_keeper: two-digit BCD game score with saturating hit/miss counting
// and a high-score register committed at game end.           Revision 1.0
// ============================================================================

`ifndef BCD_BIT_WIDTH
`define BCD_BIT_WIDTH 4
`endif
`ifndef STOP
`define STOP 2'b00
`endif

module score_keeper #(
  parameter int SCORE_MAX  = 99,
  parameter int PENALTY_EN = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                state,
  input  logic                      hit,
  input  logic                      miss,
  output logic [`BCD_BIT_WIDTH-1:0] score_tens,
  output logic [`BCD_BIT_WIDTH-1:0] score_ones,
  output logic [`BCD_BIT_WIDTH-1:0] hs_tens,
  output logic [`BCD_BIT_WIDTH-1:0] hs_ones,
  output logic                      new_record
);

  localparam logic [6:0] C_SCORE_MAX = 7'(SCORE_MAX);
  localparam logic       C_PENALTY   = (PENALTY_EN != 0);

  logic                      hit_q, miss_q;
  logic [1:0]                state_q;
  logic [`BCD_BIT_WIDTH-1:0] tens_q, ones_q, tens_d, ones_d;
  logic [`BCD_BIT_WIDTH-1:0] hs_tens_q, hs_ones_q, hs_tens_d, hs_ones_d;
  logic                      rec_q, rec_d;

  logic       hit_rise, miss_rise, game_start, game_end, do_inc, do_dec;
  logic [6:0] score_val, hs_val;

  assign hit_rise   = hit & ~hit_q;
  assign miss_rise  = miss & ~miss_q & C_PENALTY;
  assign game_start = (state_q == `STOP) && (state != `STOP);
  assign game_end   = (state_q != `STOP) && (state == `STOP);

  // Binary views of the BCD pairs, used only for magnitude comparisons.
  assign score_val = ({3'b000, tens_q} * 7'd10) + {3'b000, ones_q};
  assign hs_val    = ({3'b000, hs_tens_q} * 7'd10) + {3'b000, hs_ones_q};

  // Simultaneous hit and penalised miss cancel each other out.
  assign do_inc = hit_rise && !miss_rise && (score_val < C_SCORE_MAX);
  assign do_dec = miss_rise && !hit_rise && (score_val != 7'd0);

  always_comb begin
    tens_d    = tens_q;
    ones_d    = ones_q;
    hs_tens_d = hs_tens_q;
    hs_ones_d = hs_ones_q;
    rec_d     = rec_q;
    if (game_start) begin
      tens_d = '0;
      ones_d = '0;
      rec_d  = 1'b0;
    end else if (state == `STOP) begin
      if (game_end) begin
        if (score_val > hs_val) begin
          hs_tens_d = tens_q;
          hs_ones_d = ones_q;
          rec_d     = 1'b1;
        end else begin
          rec_d = 1'b0;
        end
      end
    end else if (do_inc) begin
      if (ones_q == 4'd9) begin
        ones_d = '0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (do_dec) begin
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      state_q   <= `STOP;
      tens_q    <= '0;
      ones_q    <= '0;
      hs_tens_q <= '0;
      hs_ones_q <= '0;
      rec_q     <= 1'b0;
    end else begin
      hit_q     <= hit;
      miss_q    <= miss;
      state_q   <= state;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      hs_tens_q <= hs_tens_d;
      hs_ones_q <= hs_ones_d;
      rec_q     <= rec_d;
    end
  end

  assign score_tens = tens_q;
  assign score_ones = ones_q;
  assign hs_tens    = hs_tens_q;
  assign hs_ones    = hs_ones_q;
  assign new_record = rec_q;

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// tb_score_keeper: directed bench with an integer-score reference model for
// a penalising and a non-penalising instance.                  Revision 1.0
// ============================================================================

module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] state;
  logic       hit, miss;
  logic       chk_en;

  logic [3:0] st0, so0, ht0, ho0, st1, so1, ht1, ho1;
  logic       nr0, nr1;

  int tests = 0;
  int fails = 0;

  // Reference model: index 0 = penalty enabled, index 1 = penalty disabled.
  int   sc [2];
  int   hs [2];
  bit   rc [2];
  bit   p_hit, p_miss;
  logic [1:0] p_state;

  always #5 clk = ~clk;

  score_keeper #(.SCORE_MAX(99), .PENALTY_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .hit(hit), .miss(miss),
    .score_tens(st0), .score_ones(so0), .hs_tens(ht0), .hs_ones(ho0),
    .new_record(nr0)
  );

  score_keeper #(.SCORE_MAX(99), .PENALTY_EN(0)) dut_np (
    .clk(clk), .rst_n(rst_n), .state(state), .hit(hit), .miss(miss),
    .score_tens(st1), .score_ones(so1), .hs_tens(ht1), .hs_ones(ho1),
    .new_record(nr1)
  );

  function automatic int next_score(int s, bit h, bit m);
    if (h && !m) return (s < 99) ? s + 1 : s;
    if (m && !h) return (s > 0) ? s - 1 : 0;
    return s;
  endfunction

  function automatic int bcd(int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_hit   <= 1'b0;
      p_miss  <= 1'b0;
      p_state <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        sc[k] <= 0;
        hs[k] <= 0;
        rc[k] <= 1'b0;
      end
    end else begin
      p_hit   <= hit;
      p_miss  <= miss;
      p_state <= state;
      for (int k = 0; k < 2; k++) begin
        if (p_state == 2'b00 && state != 2'b00) begin
          sc[k] <= 0;
          rc[k] <= 1'b0;
        end else if (state == 2'b00) begin
          if (p_state != 2'b00) begin
            if (sc[k] > hs[k]) begin
              hs[k] <= sc[k];
              rc[k] <= 1'b1;
            end else begin
              rc[k] <= 1'b0;
            end
          end
        end else begin
          sc[k] <= next_score(sc[k], hit && !p_hit, miss && !p_miss && (k == 0));
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rst_n && chk_en) begin
      chk("cyc score p1", {24'd0, st0, so0}, bcd(sc[0]));
      chk("cyc hs p1",    {24'd0, ht0, ho0}, bcd(hs[0]));
      chk("cyc rec p1",   {31'd0, nr0},      {31'd0, rc[0]});
      chk("cyc score p0", {24'd0, st1, so1}, bcd(sc[1]));
      chk("cyc hs p0",    {24'd0, ht1, ho1}, bcd(hs[1]));
      chk("cyc rec p0",   {31'd0, nr1},      {31'd0, rc[1]});
    end
  end

  task automatic pulse_hit(int n);
    repeat (n) begin
      @(negedge clk) hit = 1'b1;
      @(negedge clk) hit = 1'b0;
    end
  endtask

  task automatic pulse_miss(int n);
    repeat (n) begin
      @(negedge clk) miss = 1'b1;
      @(negedge clk) miss = 1'b0;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    state  = 2'b00;
    hit    = 1'b0;
    miss   = 1'b0;
    chk_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset score", {24'd0, st0, so0}, 'h00);
    chk("reset hs",    {24'd0, ht0, ho0}, 'h00);
    chk("reset rec",   {31'd0, nr0},      0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    @(negedge clk) state = 2'b01;
    @(negedge clk);
    pulse_hit(3);
    chk("three hits", {24'd0, st0, so0}, 'h03);
    chk("hs idle",    {24'd0, ht0, ho0}, 'h00);

    @(negedge clk) hit = 1'b1;
    repeat (10) @(negedge clk);
    hit = 1'b0;
    @(negedge clk);
    chk("held hit once", {24'd0, st0, so0}, 'h04);

    pulse_hit(11);
    chk("carry to 15", {24'd0, st0, so0}, 'h15);

    @(negedge clk) state = 2'b10;
    @(negedge clk) state = 2'b01;
    @(negedge clk);
    chk("state jump", {24'd0, st0, so0}, 'h15);

    @(negedge clk) state = 2'b00;
    @(negedge clk);
    chk("commit hs 15", {24'd0, ht0, ho0}, 'h15);
    chk("record set",   {31'd0, nr0},      1);

    pulse_hit(2);
    chk("hit in stop", {24'd0, st0, so0}, 'h15);

    // Start cycle with a simultaneous hit edge: edge must be dropped.
    @(negedge clk) begin state = 2'b01; hit = 1'b1; end
    @(negedge clk) hit = 1'b0;
    @(negedge clk);
    chk("restart clear", {24'd0, st0, so0}, 'h00);
    chk("restart rec",   {31'd0, nr0},      0);
    chk("restart hs",    {24'd0, ht0, ho0}, 'h15);

    pulse_miss(1);
    chk("miss at zero", {24'd0, st0, so0}, 'h00);

    pulse_hit(100);
    chk("reach 99", {24'd0, st0, so0}, 'h99);
    pulse_hit(1);
    chk("saturate 99", {24'd0, st0, so0}, 'h99);

    pulse_miss(79);
    chk("down to 20", {24'd0, st0, so0}, 'h20);
    pulse_miss(1);
    chk("borrow 19", {24'd0, st0, so0}, 'h19);
    chk("np ignores miss", {24'd0, st1, so1}, 'h99);

    // End cycle with a simultaneous hit edge: ignored.
    @(negedge clk) begin state = 2'b00; hit = 1'b1; end
    @(negedge clk) hit = 1'b0;
    @(negedge clk);
    chk("end edge ignored", {24'd0, st0, so0}, 'h19);
    chk("commit hs 19",     {24'd0, ht0, ho0}, 'h19);
    chk("record again",     {31'd0, nr0},      1);

    @(negedge clk) state = 2'b01;
    @(negedge clk);
    pulse_hit(5);
    @(negedge clk) begin hit = 1'b1; miss = 1'b1; end
    @(negedge clk) begin hit = 1'b0; miss = 1'b0; end
    @(negedge clk);
    chk("hit+miss penalty", {24'd0, st0, so0}, 'h05);
    chk("hit+miss no pen",  {24'd0, st1, so1}, 'h06);

    pulse_hit(2);
    @(negedge clk) state = 2'b00;
    @(negedge clk);
    chk("low end score", {24'd0, st0, so0}, 'h07);
    chk("hs kept 19",    {24'd0, ht0, ho0}, 'h19);
    chk("no record",     {31'd0, nr0},      0);

    @(negedge clk) state = 2'b01;
    @(negedge clk);
    pulse_hit(42);
    chk("score 42", {24'd0, st0, so0}, 'h42);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst score", {24'd0, st0, so0}, 'h00);
    chk("async rst hs",    {24'd0, ht0, ho0}, 'h00);
    chk("async rst rec",   {31'd0, nr0},      0);
    chk("async rst np",    {24'd0, st1, so1, ht1, ho1}, 'h0000);
    state = 2'b00;
    @(negedge clk) rst_n = 1'b1;
    pulse_hit(1);
    chk("hit after rst stop", {24'd0, st0, so0}, 'h00);

    @(negedge clk) state = 2'b01;
    @(negedge clk);
    pulse_hit(1);
    chk("normal start post rst", {24'd0, st0, so0}, 'h01);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game score and high-score bookkeeping for whack-a-mole.
- Sits directly upstream of the seven-segment scan controller:
  - Current score drives scan digits 2/3 (tens/ones).
  - High score drives the p1/p0 digits shown on the high-score button or in STOP.
- Counts hits and misses in two-digit BCD, saturating.
- Clears on game start; commits a new high score on game end.

Parameters:
- SCORE_MAX, 99, saturation ceiling in decimal (0..99); compared as tens*10+ones.
- PENALTY_EN, 1, when 1 a miss decrements the score; when 0 misses are ignored.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- state  input  2  game state, codebase encoding; `STOP` = idle/game over, any other code = game active
- hit  input  1  level, high while a correct whack is registered (multi-cycle allowed)
- miss  input  1  level, high while a wrong whack is registered (multi-cycle allowed)
- score_tens  output  `BCD_BIT_WIDTH  current score tens digit (to scan in2)
- score_ones  output  `BCD_BIT_WIDTH  current score ones digit (to scan in3)
- hs_tens  output  `BCD_BIT_WIDTH  high score tens digit (to scan p1)
- hs_ones  output  `BCD_BIT_WIDTH  high score ones digit (to scan p0)
- new_record  output  1  high when the last finished game set a new high score

Behaviour:
- Clock/reset:
  - One clock. Reset is asynchronous and active-low.
  - All outputs and internal registers reset to 0 (hit_q, miss_q, state_q reset to 0; state_q's reset value is treated as `STOP`).
- Edge detection:
  - hit_q and miss_q register the previous cycle's inputs.
  - hit_rise = hit & ~hit_q; miss_rise = miss & ~miss_q.
  - A level held N cycles counts once.
- Phase tracking:
  - state_q registers the previous state.
  - start = (state_q == `STOP`) && (state != `STOP`).
  - end = (state_q != `STOP`) && (state == `STOP`).
- Score update: registered, visible the cycle after the rising edge is sampled. Per-cycle priority:
  1. start: score <= 00, new_record <= 0; any hit_rise/miss_rise that cycle is dropped.
  2. state == `STOP`: score holds; edges are ignored.
  3. hit_rise && miss_rise (PENALTY_EN = 1): no change.
  4. hit_rise: if score < SCORE_MAX, BCD increment: ones 9 -> 0 with tens+1; otherwise hold at SCORE_MAX.
  5. miss_rise && PENALTY_EN: if score > 0, BCD decrement: ones 0 -> 9 with tens-1; otherwise hold at 00.
  6. With PENALTY_EN = 0, miss is ignored entirely, so rule 3 does not apply and a simultaneous hit increments normally.
- Digit invariant: every digit stays in 0..9; never emit A..F.
- High-score commit on end, evaluated on the score value held that cycle:
  - If score > high score: hs_tens/hs_ones <= score, new_record <= 1.
  - Else: no change, new_record <= 0.
  - An edge arriving in the end cycle is ignored; the state is already `STOP`.
- new_record holds until the next start or reset.
- High score is never cleared except by rst_n.
- State jumps between two non-`STOP` codes: no effect.
- Reset mid-game: everything returns to 0 immediately (asynchronous); the next rising edge of state away from `STOP` is a normal start.
- No combinational input-to-output paths; all outputs are registers.

Test Plan:
- Reset, then state STOP -> active; pulse hit 3x (1 cycle each, gaps) -> score_tens/ones = 0/3, one cycle after each pulse; hs = 0/0.
- Hold hit high 10 cycles -> score increments by exactly 1; drive 12 pulses from 0/3 -> 1/5 (ones wraps 9 -> 0, tens carries).
- Load to 9/9 via 99 hits, one more hit -> stays 9/9. Fresh game: miss at 0/0 -> stays 0/0. At 2/0, miss -> 1/9.
- Same cycle hit and miss rise at 0/5 -> stays 0/5. Repeat with PENALTY_EN = 0 -> 0/6.
- Game ends at 1/5 with hs 0/0 -> hs = 1/5, new_record = 1. Restart: score 0/0, new_record 0. End at 0/7 -> hs stays 1/5, new_record 0.
- Assert rst_n low mid-game at score 4/2, hs 1/5 -> all outputs 0 asynchronously (before the next clk edge). After release, hit while state STOP -> no change.
